// File: rtl/fetch_controller.sv
// IF-stage fetch sequencer: owns the fetch PC, keeps one request outstanding against a
// req/ack instruction memory, and presents fetched words to IF/ID through a one-entry slot.
module fetch_controller #(
    parameter int unsigned     N        = 32,
    parameter logic [N-1:0]    RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         freeze,
    input  logic         branchTaken,
    input  logic [N-1:0] branchAddr,
    output logic         imemReq,
    output logic [N-1:0] imemAddr,
    input  logic         imemAck,
    input  logic [N-1:0] imemData,
    output logic [N-1:0] PCF,
    output logic [N-1:0] instructionF,
    output logic         validF
);

    localparam logic [N-1:0] PC_STEP = N'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e       state_q;
    logic [N-1:0] fetch_pc_q;
    logic [N-1:0] drain_addr_q;
    logic [N-1:0] slot_instr_q;
    logic [N-1:0] slot_pc_q;
    logic         slot_valid_q;
    logic [N-1:0] buf_instr_q;
    logic [N-1:0] buf_pc_q;

    logic         consume;
    logic [N-1:0] fetch_pc_next;

    assign consume       = slot_valid_q && !freeze;
    assign fetch_pc_next = fetch_pc_q + PC_STEP;

    // Request side is a pure function of state so the address cannot move before ack.
    assign imemReq  = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign imemAddr = (state_q == S_DRAIN) ? drain_addr_q : fetch_pc_q;

    assign PCF          = slot_pc_q;
    assign instructionF = slot_instr_q;
    assign validF       = slot_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            drain_addr_q <= RESET_PC;
            slot_instr_q <= '0;
            slot_pc_q    <= '0;
            slot_valid_q <= 1'b0;
            buf_instr_q  <= '0;
            buf_pc_q     <= '0;
        end else if (branchTaken) begin
            // Redirect wins over freeze; an unacked request must still be drained.
            slot_valid_q <= 1'b0;
            buf_instr_q  <= '0;
            buf_pc_q     <= '0;
            fetch_pc_q   <= branchAddr;
            case (state_q)
                S_FETCH: begin
                    if (!imemAck) begin
                        drain_addr_q <= fetch_pc_q;
                        state_q      <= S_DRAIN;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_DRAIN: state_q <= imemAck ? S_FETCH : S_DRAIN;
                default: state_q <= S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (imemAck) begin
                        fetch_pc_q <= fetch_pc_next;
                        if (!slot_valid_q || consume) begin
                            slot_instr_q <= imemData;
                            slot_pc_q    <= fetch_pc_next;
                            slot_valid_q <= 1'b1;
                        end else begin
                            buf_instr_q <= imemData;
                            buf_pc_q    <= fetch_pc_next;
                            state_q     <= S_STALL;
                        end
                    end else if (consume) begin
                        slot_valid_q <= 1'b0;
                    end
                end
                S_STALL: begin
                    if (!freeze) begin
                        slot_instr_q <= buf_instr_q;
                        slot_pc_q    <= buf_pc_q;
                        slot_valid_q <= 1'b1;
                        state_q      <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    // Stale data is dropped; the slot only drains.
                    if (consume) begin
                        slot_valid_q <= 1'b0;
                    end
                    if (imemAck) begin
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the IF stage against an instruction memory with variable-latency req/ack handshake. Owns the fetch PC, issues one outstanding fetch at a time, and presents fetched instructions to the IF/ID register as a one-entry output slot. Honours `freeze` from hazard detection and redirects on taken branches from EX, discarding stale in-flight fetches. Sits between the instruction memory and the IF/ID pipeline register, replacing the free-running PC register/adder/mux sequencing.

## Interface

Parameters:
- `N`, 32: address/instruction width.
- `RESET_PC`, 0: first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `freeze`  in  1  hazard stall; IF/ID does not consume the slot while high.
- `branchTaken`  in  1  single-cycle pulse; redirect fetch.
- `branchAddr`  in  N  redirect target, valid with `branchTaken`.
- `imemReq`  out  1  fetch request.
- `imemAddr`  out  N  fetch address; stable while `imemReq` is high and awaiting ack.
- `imemAck`  in  1  one-cycle pulse; `imemData` valid in the same cycle. May arrive in the first `imemReq` cycle.
- `imemData`  in  N  returned instruction.
- `PCF`  out  N  address+4 of the instruction in the slot.
- `instructionF`  out  N  slot instruction.
- `validF`  out  1  slot holds a live instruction.

## Operation

Registers:
- `fetchPC`: next/current fetch address.
- `drainAddr`: address of an abandoned request.
- Slot: `instructionF`, `PCF`, `validF`.
- Hold buffer: instruction plus its PC+4.
- Consume condition: `validF && !freeze`.

States:
- IDLE: reset state. `imemReq`=0. Goes to FETCH unconditionally on the next edge.
- FETCH: `imemReq`=1, `imemAddr`=`fetchPC`.
  - Ack, no branch, slot free or being consumed: load the slot with data and `fetchPC`+4, set `validF`=1, `fetchPC`+=4, stay in FETCH.
  - Ack, no branch, slot full and `freeze`=1: write data and `fetchPC`+4 into the buffer, `fetchPC`+=4, go to STALL.
  - No ack: if the slot is consumed, `validF`<=0.
- STALL: `imemReq`=0. Slot holds. When `freeze`=0: move the buffer into the slot, `validF`=1, go to FETCH.
- DRAIN: `imemReq`=1, `imemAddr`=`drainAddr`. The request is held until ack. Ack data is discarded and never enters the slot. On ack, go to FETCH, which then fetches `fetchPC`. If the slot is consumed, `validF`<=0.

Branch handling (`branchTaken`=1) has priority over everything else, including `freeze`:
- `validF`<=0 and the buffer is discarded.
- `fetchPC`<=`branchAddr`.
- Next state by current state and ack:
  - FETCH without ack: `drainAddr`<=`fetchPC`, go to DRAIN.
  - FETCH with ack: data discarded, stay in FETCH.
  - STALL or IDLE: go to FETCH.
  - DRAIN without ack: stay in DRAIN; the target is updated, `drainAddr` is unchanged.
  - DRAIN with ack: go to FETCH.

Arithmetic and invariants:
- PC arithmetic is N-bit modulo 2^N: `RESET_PC`=0xFFFFFFFC gives `PCF`=0x00000000.
- At most one outstanding request; `imemAddr` never changes before ack.
- An `imemAck` in IDLE or STALL is a protocol violation; the bench asserts it never happens.

## Timing

Reset values (asynchronous, immediately on `rst`):
- state=IDLE, `fetchPC`=`RESET_PC`.
- `imemReq`=0, `imemAddr`=`RESET_PC`.
- `validF`=0, `PCF`=0, `instructionF`=0, buffer cleared.

Other timing:
- `imemReq`/`imemAddr` are combinational from state and registers. Slot outputs are registered.
- Reset mid-fetch drops the outstanding request. The memory must tolerate this.
- First request: cycle 1 after `rst` deasserts is IDLE; cycle 2 has `imemReq`=1.
- With zero-latency memory, throughput is one instruction per cycle. The slot is valid one edge after the ack.
- Latency-L memory gives one instruction per L+1 cycles (ack edge, then re-request).
- Redirect penalty: a branch with no outstanding request yields a new request the next cycle. A branch with an outstanding request adds the remaining drain cycles.

## Test plan

1. Reset and startup, `RESET_PC`=0:
   - `rst` high -> `imemReq`=0, `validF`=0, `PCF`=0.
   - After release -> `imemReq`=1 with `imemAddr`=0 on the 2nd cycle.
2. Zero-latency memory, `freeze`=0 -> `imemAddr` 0,4,8,... on consecutive cycles; `PCF` 4,8,12,... with `validF` held at 1.
3. Freeze over ack:
   - `freeze`=1 while slot=instr@0 and ack for addr 4 arrives -> STALL, `imemReq`=0, slot unchanged for 3 frozen cycles.
   - `freeze`=0 -> slot=instr@4 with `PCF`=8; next request addr 8.
4. Redirect while outstanding:
   - 3-cycle memory, `branchTaken` with `branchAddr`=0x100 one cycle after request to 0x8 -> `imemAddr` stays 0x8 until ack, data dropped, `validF`=0.
   - Then request 0x100; slot `PCF`=0x104.
5. Branch with freeze in STALL, `branchAddr`=0x200 -> `validF`=0 next cycle, buffer dropped, request 0x200 the following cycle.
6. Wrap-around, `RESET_PC`=0xFFFFFFFC -> first slot `PCF`=0x00000000, second request `imemAddr`=0x00000000.
